// File: rtl/stream_demux_if.sv
// Stream demux bus bundle: one valid/ready input stream and N_OUT valid/ready output channels.
// Output channel i occupies out_data[i*WIDTH +: WIDTH], out_last[i], out_valid[i], out_ready[i].
interface stream_demux_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_OUT = 3,
  parameter int unsigned SEL_W = 2
);

  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic                   in_last;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic [N_OUT-1:0]       out_last;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;

  // Source of the input stream and sink of all output channels.
  modport master (
    output in_data, in_sel, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );

  // The demux itself.
  modport slave (
    input  in_data, in_sel, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid
  );

endinterface

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with packet-level routing.
// The channel chosen on a packet's first beat is held until its last beat; invalid channels drop.
module stream_demux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_OUT = 3,
  parameter int unsigned SEL_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  stream_demux_if.slave       bus,
  output logic                busy,
  output logic [7:0]          drop_count
);

  localparam int unsigned N_SEL = 1 << SEL_W;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;

  logic [SEL_W-1:0]       sel_eff_c;
  logic                   sel_ok_c;
  logic                   in_ready_c;
  logic                   accept_c;
  logic [N_SEL-1:0]       vld_pad_c;
  logic [N_SEL-1:0]       rdy_pad_c;
  logic [N_OUT-1:0]       load_c;

  logic [N_OUT*WIDTH-1:0] data_q, data_d;
  logic [N_OUT-1:0]       last_q, last_d;
  logic [N_OUT-1:0]       valid_q, valid_d;
  logic [CNT_W-1:0]       drop_q, drop_d;

  // FSM state and locked select register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Next state: lock the select on a non-last first beat, release on the last beat.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c && !bus.in_last) begin
          state_d = ROUTE;
          sel_d   = bus.in_sel;
        end
      end
      ROUTE: begin
        if (accept_c && bus.in_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Routing decode; vectors are padded to 2^SEL_W so any select indexes safely.
  always_comb begin
    sel_eff_c  = (state_q == ROUTE) ? sel_q : bus.in_sel;
    sel_ok_c   = 32'(sel_eff_c) < N_OUT;
    vld_pad_c  = N_SEL'(valid_q);
    rdy_pad_c  = N_SEL'(bus.out_ready);
    in_ready_c = 1'b1;
    if (sel_ok_c) begin
      in_ready_c = !vld_pad_c[sel_eff_c] || rdy_pad_c[sel_eff_c];
    end
    accept_c = bus.in_valid && in_ready_c;
    load_c   = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      load_c[i] = accept_c && sel_ok_c && (sel_eff_c == SEL_W'(i));
    end
  end

  // Per-channel one-entry registers and the saturating drop counter.
  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (load_c[i]) begin
        data_d[i*WIDTH +: WIDTH] = bus.in_data;
        last_d[i]                = bus.in_last;
        valid_d[i]               = 1'b1;
      end else if (bus.out_ready[i]) begin
        valid_d[i] = 1'b0;
      end
    end
    if (accept_c && !sel_ok_c && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      last_q  <= '0;
      valid_q <= '0;
      drop_q  <= '0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = valid_q;
  assign busy          = (state_q == ROUTE);
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: vector table for routing/backpressure/drop,
// plus hand sequences for drop saturation and mid-packet reset.
module tb_stream_demux;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N_OUT = 3;
  localparam int unsigned SEL_W = 2;
  localparam int          NVEC  = 14;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] drop_count;

  int n_checks = 0;
  int n_err    = 0;

  stream_demux_if #(.WIDTH(WIDTH), .N_OUT(N_OUT), .SEL_W(SEL_W)) bus ();

  stream_demux #(.WIDTH(WIDTH), .N_OUT(N_OUT), .SEL_W(SEL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         v;
    logic [1:0] sel;
    logic [7:0] d;
    bit         last;
    logic [2:0] ordy;
    bit         e_rdy;
    logic [2:0] e_ov;
    bit         chk;
    int         ch;
    logic [7:0] e_d;
    bit         e_last;
    bit         e_busy;
    logic [7:0] e_drop;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] sel, input logic [7:0] d,
                       input bit last, input logic [2:0] ordy);
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_data   = d;
    bus.in_last   = last;
    bus.out_ready = ordy;
  endtask

  initial begin
    //          v  sel   data   last ordy    rdy  ov      chk ch data   lst busy drop
    vecs[0]  = '{1, 2'd1, 8'hA5, 1, 3'b111, 1, 3'b010, 1, 1, 8'hA5, 1, 0, 8'd0};
    vecs[1]  = '{0, 2'd0, 8'h00, 0, 3'b111, 1, 3'b000, 0, 0, 8'h00, 0, 0, 8'd0};
    vecs[2]  = '{1, 2'd2, 8'h11, 0, 3'b111, 1, 3'b100, 1, 2, 8'h11, 0, 1, 8'd0};
    vecs[3]  = '{1, 2'd0, 8'h22, 0, 3'b111, 1, 3'b100, 1, 2, 8'h22, 0, 1, 8'd0};
    vecs[4]  = '{1, 2'd0, 8'h33, 1, 3'b111, 1, 3'b100, 1, 2, 8'h33, 1, 0, 8'd0};
    vecs[5]  = '{0, 2'd0, 8'h00, 0, 3'b110, 1, 3'b000, 0, 0, 8'h00, 0, 0, 8'd0};
    vecs[6]  = '{1, 2'd0, 8'h44, 1, 3'b110, 1, 3'b001, 1, 0, 8'h44, 1, 0, 8'd0};
    vecs[7]  = '{1, 2'd0, 8'h55, 1, 3'b110, 0, 3'b001, 1, 0, 8'h44, 1, 0, 8'd0};
    vecs[8]  = '{1, 2'd0, 8'h55, 1, 3'b111, 1, 3'b001, 1, 0, 8'h55, 1, 0, 8'd0};
    vecs[9]  = '{0, 2'd0, 8'h00, 0, 3'b110, 0, 3'b001, 1, 0, 8'h55, 1, 0, 8'd0};
    vecs[10] = '{1, 2'd1, 8'h66, 1, 3'b110, 1, 3'b011, 1, 1, 8'h66, 1, 0, 8'd0};
    vecs[11] = '{0, 2'd0, 8'h00, 0, 3'b010, 0, 3'b001, 1, 0, 8'h55, 1, 0, 8'd0};
    vecs[12] = '{1, 2'd3, 8'h77, 0, 3'b111, 1, 3'b000, 0, 0, 8'h00, 0, 1, 8'd1};
    vecs[13] = '{1, 2'd0, 8'h88, 1, 3'b000, 1, 3'b000, 0, 0, 8'h00, 0, 0, 8'd2};

    rst_n = 1'b0;
    drive(0, 2'd0, 8'h00, 0, 3'b111);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov",   32'(bus.out_valid), 32'h0);
    check("rst_data", 32'(bus.out_data),  32'h0);
    check("rst_last", 32'(bus.out_last),  32'h0);
    check("rst_busy", 32'(busy),          32'h0);
    check("rst_drop", 32'(drop_count),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < NVEC; k++) begin
      @(negedge clk);
      drive(vecs[k].v, vecs[k].sel, vecs[k].d, vecs[k].last, vecs[k].ordy);
      #1;
      check($sformatf("v%0d_in_ready", k), 32'(bus.in_ready), 32'(vecs[k].e_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", k), 32'(bus.out_valid), 32'(vecs[k].e_ov));
      check($sformatf("v%0d_busy", k),      32'(busy),          32'(vecs[k].e_busy));
      check($sformatf("v%0d_drop", k),      32'(drop_count),    32'(vecs[k].e_drop));
      if (vecs[k].chk) begin
        check($sformatf("v%0d_data", k), 32'(bus.out_data[vecs[k].ch*WIDTH +: WIDTH]), 32'(vecs[k].e_d));
        check($sformatf("v%0d_last", k), 32'(bus.out_last[vecs[k].ch]), 32'(vecs[k].e_last));
      end
    end

    // Drop counter saturation: 300 more invalid single-beat packets on top of 2.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(1, 2'd3, 8'(i), 1, 3'b111);
      #1;
      check("drop_in_ready", 32'(bus.in_ready), 32'h1);
      @(posedge clk);
      #1;
      if (i == 99)  check("drop_mid", 32'(drop_count), 32'd102);
      if (i == 252) check("drop_sat_reach", 32'(drop_count), 32'd255);
    end
    check("drop_sat",   32'(drop_count),    32'd255);
    check("drop_no_ov", 32'(bus.out_valid), 32'h0);

    // Mid-packet reset: first beat of a 4-beat packet to channel 0, then reset.
    @(negedge clk);
    drive(1, 2'd0, 8'h01, 0, 3'b000);
    @(posedge clk);
    #1;
    check("pkt_b0_ov",   32'(bus.out_valid), 32'h1);
    check("pkt_b0_busy", 32'(busy),          32'h1);
    drive(1, 2'd0, 8'h02, 0, 3'b000);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov",   32'(bus.out_valid), 32'h0);
    check("mid_rst_busy", 32'(busy),          32'h0);
    check("mid_rst_drop", 32'(drop_count),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 2'd2, 8'h5A, 1, 3'b111);
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;
    check("post_rst_ov",   32'(bus.out_valid), 32'b100);
    check("post_rst_data", 32'(bus.out_data[2*WIDTH +: WIDTH]), 32'h5A);
    check("post_rst_last", 32'(bus.out_last[2]), 32'h1);
    check("post_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    drive(0, 2'd0, 8'h00, 0, 3'b111);
    @(posedge clk);
    #1;
    check("post_rst_drain", 32'(bus.out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered 1-to-N stream demultiplexer with packet-level routing, the counterpart of the team's combinational 2:1 select mux.
- Accepts one valid/ready input stream and steers each packet to one of N_OUT output channels.
- Channel is taken from in_sel on a packet's first beat and held until its last beat.
- Beats addressed to a non-existent channel are consumed, dropped and counted.

Parameters:
- WIDTH, 8, data width per beat.
- N_OUT, 3, number of output channels (1..2^SEL_W).
- SEL_W, 2, select width; sel values >= N_OUT are invalid.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  WIDTH  input beat payload.
- in_sel  input  SEL_W  destination channel; sampled only on a packet's first beat.
- in_last  input  1  marks the final beat of a packet.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- out_data  output  N_OUT*WIDTH  per-channel payload; channel i occupies bits [i*WIDTH +: WIDTH].
- out_last  output  N_OUT  per-channel last flag.
- out_valid  output  N_OUT  per-channel beat present.
- out_ready  input  N_OUT  per-channel downstream accept.
- busy  output  1  high while a packet is mid-route (state ROUTE).
- drop_count  output  8  saturating count of dropped beats.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, out_last=0, busy=0, drop_count=0, state=IDLE, locked select=0.
- Reset asserted mid-packet: packet is abandoned; held output beats are discarded; the next beat after reset is treated as a first beat.
- Each channel holds a one-entry output register. Latency from input accept to out_valid is 1 cycle.
- Effective select: in_sel in IDLE; locked select in ROUTE.
- in_ready when effective select is valid: !out_valid[sel] || out_ready[sel]. This gives full throughput, with back-to-back beats when downstream is ready every cycle.
- in_ready when effective select is invalid: 1 (drop path never stalls).
- Channel i register load: input accepted && effective select==i. Load captures in_data and in_last and sets out_valid[i].
- Channel i out_valid clear: out_ready[i] && out_valid[i] with no simultaneous load. A simultaneous load wins and keeps out_valid[i]=1.
- Channels are independent; a stalled channel does not block draining of the others.
- FSM IDLE:
  - Accepted beat with in_last=1: single-beat packet, stay IDLE.
  - Accepted beat with in_last=0: latch in_sel, go to ROUTE.
- FSM ROUTE:
  - in_sel is ignored.
  - Accepted beat with in_last=1: go to IDLE.
- Drop: every accepted beat whose effective select >= N_OUT increments drop_count by 1. drop_count saturates at 255 and does not wrap. Dropped beats never touch any channel register.
- in_valid=0: no state change; outputs drain normally.
- busy = (state==ROUTE); asserts the cycle after a non-last first beat is accepted.

Test Plan:
- Reset, then beat A5/sel=1/last=1 with out_ready=all-1 → next cycle out_valid=3'b010, channel 1 data=A5, out_last[1]=1, busy stays 0; channel 1 drains the following cycle.
- 3-beat packet 11,22,33 with sel=2 on beat 0 and sel=0 on beats 1–2 → all three beats appear on channel 2 in order; busy=1 after beat 0 and returns to 0 after beat 33 is accepted.
- Channel 0 held with out_ready[0]=0, one beat buffered, new sel=0 beat offered → in_ready=0 and the beat is held. Raise out_ready[0] → in_ready=1 the same cycle; beat lands the next cycle with out_valid[0] continuously 1.
- Channel 0 stalled and full, single-beat packet to sel=1 → accepted and delivered on channel 1; channel 0 contents are unchanged.
- 2-beat packet to sel=3 (invalid) → in_ready=1 for both beats, no out_valid asserts, drop_count=2; then 300 single-beat sel=3 beats → drop_count=255.
- Assert rst_n=0 after beat 1 of a 4-beat packet to sel=0 → out_valid=0, busy=0, drop_count=0 immediately. After release, beat 5A/sel=2/last=1 routes to channel 2.
